clk2ph_source: RTL and testbench

// - Clocked producer that feeds the 2-phase bundled-data pipeline stage (stage.req_in/ack_out/data_in).
// - Accepts words from the synchronous domain on a valid/ready port and buffers them in a small FIFO.
// - Issues each word as one 2-phase transaction: data_out is stable first, then req_out toggles.
//   The block then waits for the stage's ack toggle before issuing the next word.
// - Sits directly upstream of the first async stage; forms the clocked-to-async entry of the pipeline.

---
 rtl/async_hs_pkg.sv | 15 +
 rtl/clk2ph_source_if.sv | 21 ++
 rtl/clk2ph_source_sync_ff.sv | 26 ++
 rtl/clk2ph_source.sv | 129 ++++++++++++
 tb/tb_clk2ph_source.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/async_hs_pkg.sv
// rtl/async_hs_pkg.sv - shared types for the clocked-to-2-phase source
package async_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } state_t;

    typedef logic phase_t;

    localparam int DEFAULT_DW = 4;

endpackage

// File: rtl/clk2ph_source_if.sv
// rtl/clk2ph_source_if.sv - upstream word port plus 2-phase req/ack/data bundle
interface clk2ph_source_if #(
    parameter int DW = async_hs_pkg::DEFAULT_DW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          req_out;
    logic [DW-1:0] data_out;
    logic          ack_in;

    modport master (
        output in_valid, in_data, ack_in,
        input  in_ready, req_out, data_out
    );

    modport slave (
        input  in_valid, in_data, ack_in,
        output in_ready, req_out, data_out
    );
endinterface

// File: rtl/clk2ph_source_sync_ff.sv
// rtl/clk2ph_source_sync_ff.sv - plain flop chain synchronizer, resets to 0
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];
endmodule

// File: rtl/clk2ph_source.sv
// rtl/clk2ph_source.sv - buffers synchronous words and issues each as one 2-phase transaction
module clk2ph_source
    import async_hs_pkg::*;
#(
    parameter int DW          = DEFAULT_DW,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    clk2ph_source_if.slave           bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sent_cnt,
    output logic                     proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic             req_q, req_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    phase_t           ack_prev_q, ack_prev_d;
    phase_t           ack_s;
    logic             push, pop;
    logic [AW:0]      level, level_next;

    sync_ff #(.N(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.ack_in),
        .q     (ack_s)
    );

    assign level = wr_ptr_q - rd_ptr_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        push       = bus.in_valid && in_ready_q;
        ack_prev_d = ack_s;

        // Actions happen on the edge entering a state: data is registered on
        // entry to LOAD, so it is stable a full cycle before req_out moves.
        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                req_d   = ~req_q;
                state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ack_s == req_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (level != '0) begin
                        data_d  = mem_q[rd_ptr_q[AW-1:0]];
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        level_next = wr_ptr_d - rd_ptr_d;
        in_ready_d = level_next < FULL_LVL;

        // An ack edge with no request outstanding is flagged but not acted on.
        err_d = err_q | ((ack_s != ack_prev_q) && (state_q == IDLE || state_q == LOAD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            req_q      <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
            req_q      <= req_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;
    assign fifo_level   = level;
    assign sent_cnt     = cnt_q;
    assign proto_err    = err_q;
endmodule

// File: tb/tb_clk2ph_source.sv
// tb/tb_clk2ph_source.sv - self-checking bench for clk2ph_source
module tb_clk2ph_source;
    import async_hs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fifo_level;
    logic [7:0] sent_cnt;
    logic       proto_err;

    always #5 clk = ~clk;

    clk2ph_source_if #(.DW(4)) bus ();

    clk2ph_source #(
        .DW(4), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .sent_cnt   (sent_cnt),
        .proto_err  (proto_err)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    int   toggles = 0;
    bit   mon_en = 1'b0;
    logic req_prev = 1'b0;
    bit   ack_hold = 1'b0;
    bit   ack_manual = 1'b0;
    bit   ack_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage model: ack follows req after a fixed or random delay; reset with rst_n.
    initial begin : responder
        bit busy = 1'b0;
        int cnt = 0;
        bus.ack_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.ack_in = 1'b0;
                busy = 1'b0;
            end else if (ack_manual) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    bus.ack_in = bus.req_out;
                    busy = 1'b0;
                end
            end else if (!ack_hold && bus.ack_in !== bus.req_out) begin
                busy = 1'b1;
                cnt = ack_rand ? int'($urandom_range(7, 1)) : 3;
            end
        end
    end

    // Every req toggle must present the oldest word not yet delivered.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && bus.req_out !== req_prev) begin
                toggles++;
                chk("req_has_pending_word", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("data_order", 32'(bus.data_out), 32'(exp_q.pop_front()));
                end
            end
            req_prev = bus.req_out;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [3:0] w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) begin
            @(posedge clk);
            #1;
            exp_q.push_back(w);
        end else begin
            chk("push_timeout_in_ready", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sent(input logic [7:0] target, input int budget, input string tag);
        int n = 0;
        while (sent_cnt !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sent_cnt), 32'(target));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        toggles = 0;
        req_prev = bus.req_out;
        mon_en = 1'b1;
    endtask

    initial begin : stimulus
        int   t0;
        int   n;
        logic r;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_out", 32'(bus.req_out), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("idle_req_out", 32'(bus.req_out), 32'd0);
        chk("idle_sent_cnt", 32'(sent_cnt), 32'd0);

        // Single word: accepted at edge N, data at N+1, req toggles at N+2
        push_word(4'h1);
        chk("single_data_at_N", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        chk("single_data_at_N1", 32'(bus.data_out), 32'd1);
        chk("single_req_at_N1", 32'(bus.req_out), 32'd0);
        @(negedge clk);
        chk("single_req_at_N2", 32'(bus.req_out), 32'd1);
        wait_sent(8'd1, 100, "single_sent_cnt");
        repeat (3) @(negedge clk);
        chk("single_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("single_fifo_empty", 32'(fifo_level), 32'd0);

        // Burst with ack held: 4 buffered + 1 in flight, then backpressure
        ack_hold = 1'b1;
        t0 = toggles;
        for (int i = 1; i <= 5; i++) push_word(4'(i));
        chk("burst_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("burst_fifo_full", 32'(fifo_level), 32'd4);
        repeat (5) @(negedge clk);
        chk("burst_held_toggles", 32'(toggles - t0), 32'd1);
        ack_hold = 1'b0;
        push_word(4'h6);
        wait_sent(8'd7, 400, "burst_sent_cnt");
        repeat (2) @(negedge clk);
        chk("burst_toggles", 32'(toggles - t0), 32'd6);
        chk("burst_model_drained", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT with three words queued
        ack_hold = 1'b1;
        push_word(4'hA);
        push_word(4'hB);
        push_word(4'hC);
        push_word(4'hD);
        repeat (2) @(negedge clk);
        chk("midrst_state_wait", 32'(dut.state_q), 32'(WAIT));
        chk("midrst_level_before", 32'(fifo_level), 32'd3);
        do_reset();
        chk("midrst_req_out", 32'(bus.req_out), 32'd0);
        chk("midrst_fifo_level", 32'(fifo_level), 32'd0);
        chk("midrst_sent_cnt", 32'(sent_cnt), 32'd0);
        ack_hold = 1'b0;
        push_word(4'h9);
        wait_sent(8'd1, 100, "midrst_new_word_sent");
        chk("midrst_new_word_toggles", 32'(toggles), 32'd1);

        // 300 random words, random ack delay 1..7, random upstream gaps
        do_reset();
        ack_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push_word(4'($urandom));
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        n = 0;
        while ((toggles < 300 || exp_q.size() != 0) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("rand_toggles", 32'(toggles), 32'd300);
        chk("rand_sent_cnt", 32'(sent_cnt), 32'd44);
        chk("rand_proto_err", 32'(proto_err), 32'd0);
        chk("rand_model_drained", 32'(exp_q.size()), 32'd0);

        // Spurious ack while IDLE
        ack_manual = 1'b1;
        r = bus.req_out;
        bus.ack_in = ~bus.ack_in;
        repeat (5) @(negedge clk);
        chk("spur_proto_err", 32'(proto_err), 32'd1);
        chk("spur_req_unchanged", 32'(bus.req_out), 32'(r));
        repeat (10) @(negedge clk);
        chk("spur_proto_err_sticky", 32'(proto_err), 32'd1);
        chk("spur_sent_unchanged", 32'(sent_cnt), 32'd44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
